// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported I/D memory between the fetch port and the load/store port.
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that aborts a stuck access and sets a sticky bus_err.
module mem_port_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int IF_STARVE_MAX  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic [DW-1:0]     if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [AW-1:0]     dm_addr,
    input  logic [DW-1:0]     dm_wdata,
    input  logic [DW/8-1:0]   dm_wstrb,
    output logic [DW-1:0]     dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wstrb,
    input  logic              mem_ack,
    input  logic [DW-1:0]     mem_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY_IF, S_BUSY_DM} state_e;

    localparam int         SW         = DW / 8;
    localparam logic [3:0] STARVE_MAX = 4'(IF_STARVE_MAX);

    if (DW % 8 != 0 || IF_STARVE_MAX < 1 || IF_STARVE_MAX > 15 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("mem_port_arbiter: illegal parameter combination");
    end

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [3:0]      starve_q, starve_d;
    logic            tmo_hit;
    logic            done;

    // An access ends on the memory ack, or on a watchdog abort when that feature is built in.
    assign done = mem_ack | tmo_hit;

    always_comb begin
        // NOTE: every next-state signal gets its default first, so no path through the case infers a latch.
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        starve_d    = starve_q;
        unique case (state_q)
            S_IDLE: begin
                if (dm_req && (!if_req || (starve_q < STARVE_MAX))) begin
                    state_d     = S_BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_wstrb_d = dm_wstrb;
                    if (!if_req)
                        starve_d = '0;
                    else if (starve_q != 4'hF)
                        starve_d = starve_q + 4'd1;
                end else if (if_req) begin
                    state_d     = S_BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    starve_d    = '0;
                end else begin
                    mem_req_d   = 1'b0;
                end
            end
            S_BUSY_IF, S_BUSY_DM: begin
                if (done) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            starve_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            starve_q    <= starve_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          bus_err_q, bus_err_d;

    // A same-cycle ack beats the watchdog, so the abort only fires while mem_ack is low.
    assign tmo_hit   = (state_q != S_IDLE) && !mem_ack && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign tmo_d     = (state_q == S_IDLE || done) ? '0 : tmo_q + TW'(1);
    assign bus_err_d = bus_err_q | tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign tmo_hit = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign if_ready  = (state_q == S_BUSY_IF) && done;
    assign dm_ready  = (state_q == S_BUSY_DM) && done;
    // Read data is forced to zero outside an acked cycle, which also covers a watchdog abort.
    assign if_rdata  = ((state_q == S_BUSY_IF) && mem_ack) ? mem_rdata : '0;
    assign dm_rdata  = ((state_q == S_BUSY_DM) && mem_ack) ? mem_rdata : '0;
    assign stall_if  = if_req & ~if_ready;
    assign stall_dm  = dm_req & ~dm_ready;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule
